// File: rtl/sm83_pkg.sv
// rtl/sm83_pkg.sv - shared SM83 bus types, OAM DMA states and memory-map constants
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    DMA_IDLE,
    DMA_START,
    DMA_ACTIVE,
    DMA_DRAIN
  } dma_state_t;

  localparam addr_t DMA_REG_ADDR    = 16'hFF46;
  localparam addr_t OAM_BASE        = 16'hFE00;
  localparam addr_t HRAM_LO         = 16'hFF80;
  localparam addr_t HRAM_HI         = 16'hFFFE;
  localparam int    DMA_LEN_DEFAULT = 160;

  // Sources in E0..FF alias work RAM through the echo region.
  function automatic data_t dma_src_hi(input data_t reg_val);
    return (reg_val >= 8'hE0) ? data_t'(reg_val - 8'h20) : reg_val;
  endfunction

  function automatic logic is_hram_addr(input addr_t a);
    return (a >= HRAM_LO) && (a <= HRAM_HI);
  endfunction

endpackage

// File: rtl/oam_dma_bus_engine.sv
// rtl/oam_dma_bus_engine.sv - OAM DMA sequencer: source register, byte counter, one-cycle OAM write pipeline
module oam_dma_bus_engine
  import sm83_pkg::*;
#(
  parameter int DMA_LEN = DMA_LEN_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] start_src,
  input  logic [7:0] mem_rdata,
  output logic [7:0] dma_reg,
  output logic [7:0] src_hi,
  output logic [7:0] cnt,
  output logic       active,
  output logic [7:0] oam_addr,
  output logic [7:0] oam_wdata,
  output logic       oam_wen
);

  localparam logic [7:0] LAST = 8'(DMA_LEN - 1);

  dma_state_t state;
  logic       valid_q;
  logic [7:0] data_q;
  logic [7:0] idx_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= DMA_IDLE;
      dma_reg <= 8'hFF;
      cnt     <= 8'h00;
      active  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      idx_q   <= 8'h00;
    end else begin
      // Every ACTIVE cycle captures a byte, including one cut short by a restart.
      valid_q <= active;
      if (active) begin
        data_q <= mem_rdata;
        idx_q  <= cnt;
      end

      if (start) begin
        dma_reg <= start_src;
        cnt     <= 8'h00;
        state   <= DMA_START;
        active  <= 1'b0;
      end else begin
        case (state)
          DMA_IDLE: begin
            active <= 1'b0;
          end
          DMA_START: begin
            state  <= DMA_ACTIVE;
            active <= 1'b1;
          end
          DMA_ACTIVE: begin
            if (cnt == LAST) begin
              state  <= DMA_DRAIN;
              active <= 1'b0;
            end else begin
              cnt <= cnt + 8'h01;
            end
          end
          DMA_DRAIN: begin
            state  <= DMA_IDLE;
            active <= 1'b0;
          end
          default: begin
            state  <= DMA_IDLE;
            active <= 1'b0;
          end
        endcase
      end
    end
  end

  assign src_hi    = dma_src_hi(dma_reg);
  assign oam_wen   = valid_q;
  assign oam_addr  = idx_q;
  assign oam_wdata = data_q;

endmodule

// File: rtl/oam_dma_bus.sv
// rtl/oam_dma_bus.sv - core bus splitter owning FF46 OAM DMA and private HRAM port; OAM_DMA_BUS_CONFLICT_EN selects blocked-read data
module oam_dma_bus #(
  parameter int          DMA_LEN      = sm83_pkg::DMA_LEN_DEFAULT,
  parameter logic [15:0] DMA_REG_ADDR = sm83_pkg::DMA_REG_ADDR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] core_addr,
  input  logic [7:0]  core_wdata,
  input  logic        core_wen,
  output logic [7:0]  core_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_wen,
  input  logic [7:0]  mem_rdata,
  output logic [6:0]  hram_addr,
  output logic [7:0]  hram_wdata,
  output logic        hram_wen,
  input  logic [7:0]  hram_rdata,
  output logic [7:0]  oam_addr,
  output logic [7:0]  oam_wdata,
  output logic        oam_wen,
  output logic        dma_active
);
  import sm83_pkg::*;

  logic       is_hram;
  logic       is_reg;
  logic       dma_start;
  logic [7:0] dma_reg;
  logic [7:0] src_hi;
  logic [7:0] cnt;

  // HRAM wins the decode so FF46 can never shadow it.
  assign is_hram   = is_hram_addr(core_addr);
  assign is_reg    = !is_hram && (core_addr == DMA_REG_ADDR);
  assign dma_start = core_wen && is_reg;

  oam_dma_bus_engine #(
    .DMA_LEN (DMA_LEN)
  ) u_engine (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (dma_start),
    .start_src (core_wdata),
    .mem_rdata (mem_rdata),
    .dma_reg   (dma_reg),
    .src_hi    (src_hi),
    .cnt       (cnt),
    .active    (dma_active),
    .oam_addr  (oam_addr),
    .oam_wdata (oam_wdata),
    .oam_wen   (oam_wen)
  );

  assign hram_addr  = core_addr[6:0];
  assign hram_wdata = core_wdata;
  assign hram_wen   = core_wen && is_hram;
  assign mem_wdata  = core_wdata;

  always_comb begin
    mem_addr = core_addr;
    mem_wen  = 1'b0;
    if (dma_active) begin
      mem_addr = {src_hi, cnt};
    end else begin
      mem_wen = core_wen && !is_hram && !is_reg;
    end
  end

  always_comb begin
    core_rdata = mem_rdata;
    if (is_hram) begin
      core_rdata = hram_rdata;
    end else if (is_reg) begin
      core_rdata = dma_reg;
    end else if (dma_active) begin
`ifdef OAM_DMA_BUS_CONFLICT_EN
      core_rdata = mem_rdata;
`else
      core_rdata = 8'hFF;
`endif
    end
  end

endmodule

// File: tb/tb_oam_dma_bus.sv
// tb/tb_oam_dma_bus.sv - directed bench for oam_dma_bus
module tb_oam_dma_bus;

  logic        clk;
  logic        rst_n;
  logic [15:0] core_addr;
  logic [7:0]  core_wdata;
  logic        core_wen;
  logic [7:0]  core_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen;
  logic [7:0]  mem_rdata;
  logic [6:0]  hram_addr;
  logic [7:0]  hram_wdata;
  logic        hram_wen;
  logic [7:0]  hram_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_wen;
  logic        dma_active;

  int checks;
  int failures;

  oam_dma_bus dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .core_addr  (core_addr),
    .core_wdata (core_wdata),
    .core_wen   (core_wen),
    .core_rdata (core_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wen    (mem_wen),
    .mem_rdata  (mem_rdata),
    .hram_addr  (hram_addr),
    .hram_wdata (hram_wdata),
    .hram_wen   (hram_wen),
    .hram_rdata (hram_rdata),
    .oam_addr   (oam_addr),
    .oam_wdata  (oam_wdata),
    .oam_wen    (oam_wen),
    .dma_active (dma_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // System memory: fixed background pattern with a write overlay.
  bit         wr_valid [65536];
  logic [7:0] wr_data  [65536];

  function automatic logic [7:0] mem_init(input logic [15:0] a);
    case (a[15:8])
      8'hC0:   return a[7:0] ^ 8'hA5;
      8'hD0:   return a[7:0] ^ 8'h3C;
      8'hDE:   return ~a[7:0];
      default: return a[7:0] ^ a[15:8];
    endcase
  endfunction

  always_comb mem_rdata = wr_valid[mem_addr] ? wr_data[mem_addr] : mem_init(mem_addr);

  always @(posedge clk) begin
    if (mem_wen) begin
      wr_valid[mem_addr] <= 1'b1;
      wr_data[mem_addr]  <= mem_wdata;
    end
  end

  logic [7:0] hram [128];
  always_comb hram_rdata = hram[hram_addr];
  always @(posedge clk) if (hram_wen) hram[hram_addr] <= hram_wdata;

  logic [7:0] oam [256];
  int oam_writes;
  always @(posedge clk) begin
    if (oam_wen) begin
      oam[oam_addr] <= oam_wdata;
      oam_writes    <= oam_writes + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [15:0] a, input logic [7:0] d, input logic w);
    @(negedge clk);
    core_addr  = a;
    core_wdata = d;
    core_wen   = w;
    #1;
  endtask

  task automatic start_dma(input logic [7:0] src);
    step(16'hFF46, src, 1'b1);
    chk("ff46_write_not_forwarded", mem_wen, 0);
  endtask

  task automatic wait_done(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      step(16'h0000, 8'h00, 1'b0);
      if (!dma_active && !oam_wen) begin
        ok = 1'b1;
        break;
      end
    end
    chk(name, ok, 1);
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        wen;
    logic        exp_mem_wen;
    logic        exp_hram_wen;
    logic        chk_rd;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vt [10];

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int base;
    logic [7:0] exp_b;

    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    core_addr  = 16'h8123;
    core_wdata = 8'h00;
    core_wen   = 1'b0;

    vt[0] = '{16'hFF46, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFF};
    vt[1] = '{16'hC000, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[2] = '{16'hC000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A};
    vt[3] = '{16'hFF90, 8'h33, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[4] = '{16'hFF90, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
    vt[5] = '{16'hFFFE, 8'h9C, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00};
    vt[6] = '{16'hFFFE, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h9C};
    vt[7] = '{16'hFFFF, 8'h12, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vt[8] = '{16'hFF7F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h80};
    vt[9] = '{16'h1234, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h26};

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_oam_wen", oam_wen, 0);
    chk("rst_dma_active", dma_active, 0);
    chk("rst_mem_wen", mem_wen, 0);
    chk("rst_hram_wen", hram_wen, 0);
    chk("rst_mem_addr", mem_addr, 16'h8123);
    chk("rst_hram_addr", hram_addr, 7'h23);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle decode and pass-through
    for (int i = 0; i < 10; i++) begin
      step(vt[i].addr, vt[i].wdata, vt[i].wen);
      chk($sformatf("vec%0d_mem_wen", i), mem_wen, vt[i].exp_mem_wen);
      chk($sformatf("vec%0d_hram_wen", i), hram_wen, vt[i].exp_hram_wen);
      chk($sformatf("vec%0d_mem_addr", i), mem_addr, vt[i].addr);
      chk($sformatf("vec%0d_hram_addr", i), hram_addr, vt[i].addr[6:0]);
      if (vt[i].chk_rd) chk($sformatf("vec%0d_rdata", i), core_rdata, vt[i].exp_rd);
    end

    // Full transfer from C000; byte 0 carries the 5A written above
    start_dma(8'hC0);
    base = oam_writes;
    for (int k = 1; k <= 165; k++) begin
      step(16'h0000, 8'h00, 1'b0);
      chk($sformatf("t1_active_c%0d", k), dma_active, (k >= 2 && k <= 161));
      chk($sformatf("t1_oam_wen_c%0d", k), oam_wen, (k >= 3 && k <= 162));
      if (k >= 3 && k <= 162) begin
        exp_b = (k == 3) ? 8'h5A : (8'(k - 3) ^ 8'hA5);
        chk($sformatf("t1_oam_addr_c%0d", k), oam_addr, k - 3);
        chk($sformatf("t1_oam_wdata_c%0d", k), oam_wdata, exp_b);
      end
      if (k == 2)   chk("t1_mem_addr_first", mem_addr, 16'hC000);
      if (k == 161) chk("t1_mem_addr_last", mem_addr, 16'hC09F);
    end
    chk("t1_oam_write_count", oam_writes - base, 160);

    // Core traffic during ACTIVE, then restart with D0 at cycle 50
    start_dma(8'hC0);
    for (int k = 1; k <= 52; k++) begin
      case (k)
        10: begin
          step(16'hFF90, 8'h33, 1'b1);
          chk("act_hram_wen", hram_wen, 1);
          chk("act_hram_addr", hram_addr, 7'h10);
          chk("act_hram_mem_wen", mem_wen, 0);
          chk("act_dma_active", dma_active, 1);
        end
        11: begin
          step(16'hC123, 8'h00, 1'b0);
`ifdef OAM_DMA_BUS_CONFLICT_EN
          chk("act_blocked_read", core_rdata, 8'hAC);
`else
          chk("act_blocked_read", core_rdata, 8'hFF);
`endif
        end
        12: begin
          step(16'hC010, 8'hEE, 1'b1);
          chk("act_blocked_write", mem_wen, 0);
        end
        50: begin
          step(16'hFF46, 8'hD0, 1'b1);
          chk("restart_not_forwarded", mem_wen, 0);
        end
        51: begin
          step(16'h0000, 8'h00, 1'b0);
          chk("restart_start_active", dma_active, 0);
          chk("restart_pending_wen", oam_wen, 1);
          chk("restart_pending_addr", oam_addr, 48);
        end
        52: begin
          step(16'h0000, 8'h00, 1'b0);
          chk("restart_mem_addr", mem_addr, 16'hD000);
          chk("restart_oam_idle", oam_wen, 0);
        end
        default: step(16'h0000, 8'h00, 1'b0);
      endcase
    end
    wait_done("restart_done");
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== (8'(i) ^ 8'h3C)) bad++;
    chk("restart_oam_contents_bad", bad, 0);
    chk("blocked_write_mem", wr_valid[16'hC010] ? wr_data[16'hC010] : mem_init(16'hC010), 8'hB5);
    step(16'hFF46, 8'h00, 1'b0);
    chk("restart_ff46_read", core_rdata, 8'hD0);
    step(16'hFF90, 8'h00, 1'b0);
    chk("hram_during_dma_read", core_rdata, 8'h33);

    // Echo fold: FE sources DE00
    start_dma(8'hFE);
    step(16'h0000, 8'h00, 1'b0);
    step(16'h0000, 8'h00, 1'b0);
    chk("echo_mem_addr", mem_addr, 16'hDE00);
    wait_done("echo_done");
    bad = 0;
    for (int i = 0; i < 160; i++) if (oam[i] !== ~8'(i)) bad++;
    chk("echo_oam_contents_bad", bad, 0);
    step(16'hFF46, 8'h00, 1'b0);
    chk("echo_ff46_read", core_rdata, 8'hFE);

    // Async reset mid-transfer
    start_dma(8'hC0);
    for (int k = 1; k <= 80; k++) step(16'h0000, 8'h00, 1'b0);
    chk("rst_mid_active_before", dma_active, 1);
    chk("rst_mid_wen_before", oam_wen, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_oam_wen", oam_wen, 0);
    chk("rst_mid_dma_active", dma_active, 0);
    base = oam_writes;
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step(16'h0000, 8'h00, 1'b0);
      if (oam_wen || dma_active) bad++;
    end
    chk("rst_mid_quiet_cycles", bad, 0);
    chk("rst_mid_no_writes", oam_writes - base, 0);
    step(16'hFF46, 8'h00, 1'b0);
    chk("rst_mid_ff46_read", core_rdata, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
